akuma_motion_ctrl: RTL and testbench

- Per-character motion/animation sequencer for Akuma.
- Turns held-key inputs into state (IDLE/WALK/JUMP/PUNCH), screen position (AkumaX/AkumaY), facing and animation frame index.
- Outputs feed the Akuma left/right sprite renderers (which take AkumaX/AkumaY) and the hit-detection logic.
- All state advances once per video frame on frame_tick; outputs stay stable for the rest of the frame.

---
 rtl/akuma_motion_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_akuma_motion_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/akuma_motion_ctrl.sv
// Akuma motion/animation sequencer.
// Turns held keys into IDLE/WALK/JUMP/PUNCH state, sprite position, facing,
// animation frame and punch hitbox enable. Everything advances once per
// video frame (frame_tick) unless frozen, and every output is a register.
module akuma_motion_ctrl #(
    parameter int X_INIT       = 100,
    parameter int GROUND_Y     = 240,
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 499,
    parameter int WALK_STEP    = 3,
    parameter int JUMP_V0      = 12,
    parameter int GRAVITY      = 1,
    parameter int PUNCH_FRAMES = 12,
    parameter int ACT_START    = 3,
    parameter int ACT_END      = 8,
    parameter int ANIM_DIV     = 6
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       freeze,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_jump,
    input  logic       key_punch,
    input  logic [9:0] opp_x,
    output logic [9:0] AkumaX,
    output logic [9:0] AkumaY,
    output logic       facing_left,
    output logic [2:0] frame_idx,
    output logic [1:0] state,
    output logic       punch_active
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WALK  = 2'd1,
        S_JUMP  = 2'd2,
        S_PUNCH = 2'd3
    } state_t;

    localparam logic signed [10:0] L_STEP   = 11'(WALK_STEP);
    localparam logic signed [10:0] L_GROUND = 11'(GROUND_Y);

    state_t             r_state;
    logic [9:0]         r_x;
    logic [9:0]         r_y;
    logic               r_facing;
    logic [2:0]         r_frame;
    logic               r_punch_active;
    logic signed [7:0]  r_vy;
    logic [2:0]         r_anim_cnt;
    logic [3:0]         r_punch_cnt;
    logic signed [1:0]  r_jump_dir;

    logic               w_tick;
    logic               w_one_dir;
    logic signed [10:0] w_x_signed;
    logic signed [10:0] w_walk_dx;
    logic signed [10:0] w_jump_dx;
    logic [9:0]         w_x_walk;
    logic [9:0]         w_x_jump;
    logic signed [10:0] w_y_next;
    logic signed [7:0]  w_vy_dec;
    logic [3:0]         w_punch_inc;
    logic               w_anim_wrap;

    // X is computed signed so a step left of zero saturates instead of wrapping.
    function automatic logic [9:0] clampX(input logic signed [10:0] v);
        if (v < 11'(X_MIN))
            clampX = 10'(X_MIN);
        else if (v > 11'(X_MAX))
            clampX = 10'(X_MAX);
        else
            clampX = v[9:0];
    endfunction

    assign w_tick      = frame_tick & ~freeze;
    assign w_one_dir   = key_left ^ key_right;
    assign w_x_signed  = $signed({1'b0, r_x});
    assign w_walk_dx   = key_left ? -L_STEP : L_STEP;
    assign w_x_walk    = clampX(w_x_signed + w_walk_dx);
    assign w_x_jump    = clampX(w_x_signed + w_jump_dx);
    assign w_y_next    = $signed({1'b0, r_y}) - $signed({{3{r_vy[7]}}, r_vy});
    assign w_vy_dec    = r_vy - 8'(GRAVITY);
    assign w_punch_inc = r_punch_cnt + 4'd1;
    assign w_anim_wrap = (r_anim_cnt == 3'(ANIM_DIV - 1));

    // Horizontal drift while airborne follows the direction latched at takeoff.
    always_comb begin
        w_jump_dx = '0;
        if (r_jump_dir == 2'sb01)
            w_jump_dx = L_STEP;
        else if (r_jump_dir == 2'sb11)
            w_jump_dx = -L_STEP;
    end

    // Per-frame state machine: movement, physics, punch timing and outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state        <= S_IDLE;
            r_x            <= 10'(X_INIT);
            r_y            <= 10'(GROUND_Y);
            r_facing       <= 1'b0;
            r_frame        <= 3'd0;
            r_punch_active <= 1'b0;
            r_vy           <= 8'sd0;
            r_anim_cnt     <= 3'd0;
            r_punch_cnt    <= 4'd0;
            r_jump_dir     <= 2'sb00;
        end else if (w_tick) begin
            case (r_state)
                S_IDLE, S_WALK: begin
                    r_facing <= (opp_x < r_x);
                    if (key_punch) begin
                        r_state        <= S_PUNCH;
                        r_punch_cnt    <= 4'd0;
                        r_frame        <= 3'd6;
                        r_punch_active <= (ACT_START == 0);
                    end else if (key_jump) begin
                        r_state <= S_JUMP;
                        r_vy    <= 8'(JUMP_V0);
                        r_frame <= (JUMP_V0 > 0) ? 3'd4 : 3'd5;
                        if (key_left && !key_right)
                            r_jump_dir <= 2'sb11;
                        else if (key_right && !key_left)
                            r_jump_dir <= 2'sb01;
                        else
                            r_jump_dir <= 2'sb00;
                    end else if (w_one_dir) begin
                        r_state <= S_WALK;
                        r_x     <= w_x_walk;
                        if (r_state != S_WALK) begin
                            r_anim_cnt <= 3'd0;
                            r_frame    <= 3'd0;
                        end else if (w_anim_wrap) begin
                            r_anim_cnt <= 3'd0;
                            r_frame    <= {1'b0, r_frame[1:0] + 2'd1};
                        end else begin
                            r_anim_cnt <= r_anim_cnt + 3'd1;
                        end
                    end else begin
                        r_state    <= S_IDLE;
                        r_frame    <= 3'd0;
                        r_anim_cnt <= 3'd0;
                    end
                end
                S_JUMP: begin
                    r_x <= w_x_jump;
                    if (w_y_next >= L_GROUND) begin
                        r_y     <= 10'(GROUND_Y);
                        r_vy    <= 8'sd0;
                        r_state <= S_IDLE;
                        r_frame <= 3'd0;
                    end else begin
                        r_y     <= w_y_next[9:0];
                        r_vy    <= w_vy_dec;
                        r_frame <= (w_vy_dec > 8'sd0) ? 3'd4 : 3'd5;
                    end
                end
                S_PUNCH: begin
                    if (r_punch_cnt == 4'(PUNCH_FRAMES - 1)) begin
                        r_state        <= S_IDLE;
                        r_punch_cnt    <= 4'd0;
                        r_frame        <= 3'd0;
                        r_punch_active <= 1'b0;
                    end else begin
                        r_punch_cnt    <= w_punch_inc;
                        r_punch_active <= (w_punch_inc >= 4'(ACT_START)) &&
                                          (w_punch_inc <= 4'(ACT_END));
                    end
                end
            endcase
        end
    end

    assign AkumaX       = r_x;
    assign AkumaY       = r_y;
    assign facing_left  = r_facing;
    assign frame_idx    = r_frame;
    assign state        = r_state;
    assign punch_active = r_punch_active;

endmodule

// File: tb/tb_akuma_motion_ctrl.sv
// Testbench for akuma_motion_ctrl: directed scenarios followed by random
// key/freeze/reset traffic, all compared against a frame-level model.
module tb_akuma_motion_ctrl;

    localparam int X_INIT       = 100;
    localparam int GROUND_Y     = 240;
    localparam int X_MIN        = 0;
    localparam int X_MAX        = 499;
    localparam int WALK_STEP    = 3;
    localparam int JUMP_V0      = 12;
    localparam int GRAVITY      = 1;
    localparam int PUNCH_FRAMES = 12;
    localparam int ACT_START    = 3;
    localparam int ACT_END      = 8;
    localparam int ANIM_DIV     = 6;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       freeze = 1'b0;
    logic       key_left = 1'b0;
    logic       key_right = 1'b0;
    logic       key_jump = 1'b0;
    logic       key_punch = 1'b0;
    logic [9:0] opp_x = 10'd300;
    logic [9:0] AkumaX;
    logic [9:0] AkumaY;
    logic       facing_left;
    logic [2:0] frame_idx;
    logic [1:0] state;
    logic       punch_active;

    int checks = 0;
    int failures = 0;
    int curOpp = 300;

    // Model state: 0 idle, 1 walk, 2 jump, 3 punch
    int mX, mY, mVy, mState, mFace, mAnim, mWalkFrame, mPunchCnt, mDir;

    akuma_motion_ctrl dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_tick   (frame_tick),
        .freeze       (freeze),
        .key_left     (key_left),
        .key_right    (key_right),
        .key_jump     (key_jump),
        .key_punch    (key_punch),
        .opp_x        (opp_x),
        .AkumaX       (AkumaX),
        .AkumaY       (AkumaY),
        .facing_left  (facing_left),
        .frame_idx    (frame_idx),
        .state        (state),
        .punch_active (punch_active)
    );

    // Free-running system clock
    always #5 Clk = ~Clk;

    function automatic int clampX(input int v);
        if (v < X_MIN) return X_MIN;
        if (v > X_MAX) return X_MAX;
        return v;
    endfunction

    function automatic int modelFrame();
        case (mState)
            0: return 0;
            1: return mWalkFrame;
            2: return (mVy > 0) ? 4 : 5;
            default: return 6;
        endcase
    endfunction

    function automatic int modelActive();
        return (mState == 3 && mPunchCnt >= ACT_START && mPunchCnt <= ACT_END) ? 1 : 0;
    endfunction

    task automatic modelReset();
        mX = X_INIT; mY = GROUND_Y; mVy = 0; mState = 0; mFace = 0;
        mAnim = 0; mWalkFrame = 0; mPunchCnt = 0; mDir = 0;
    endtask

    task automatic modelTick(input bit kl, input bit kr, input bit kj, input bit kp, input int ox);
        int yn;
        if (mState == 0 || mState == 1) begin
            mFace = (ox < mX) ? 1 : 0;
            if (kp) begin
                mState = 3; mPunchCnt = 0;
            end else if (kj) begin
                mState = 2; mVy = JUMP_V0;
                mDir = (kl && !kr) ? -1 : ((kr && !kl) ? 1 : 0);
            end else if (kl != kr) begin
                if (mState != 1) begin
                    mAnim = 0; mWalkFrame = 0;
                end else if (mAnim == ANIM_DIV - 1) begin
                    mAnim = 0; mWalkFrame = (mWalkFrame + 1) % 4;
                end else begin
                    mAnim++;
                end
                mState = 1;
                mX = clampX(mX + (kl ? -WALK_STEP : WALK_STEP));
            end else begin
                mState = 0;
            end
        end else if (mState == 2) begin
            yn = mY - mVy;
            mVy = mVy - GRAVITY;
            mX = clampX(mX + mDir * WALK_STEP);
            if (yn >= GROUND_Y) begin
                mY = GROUND_Y; mVy = 0; mState = 0;
            end else begin
                mY = yn;
            end
        end else begin
            if (mPunchCnt == PUNCH_FRAMES - 1) begin
                mState = 0; mPunchCnt = 0;
            end else begin
                mPunchCnt++;
            end
        end
    endtask

    task automatic checkVal(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Every output against the model
    task automatic checkOutput(input string tag);
        checkVal({tag, ".x"},     int'(AkumaX),       mX);
        checkVal({tag, ".y"},     int'(AkumaY),       mY);
        checkVal({tag, ".state"}, int'(state),        mState);
        checkVal({tag, ".face"},  int'(facing_left),  mFace);
        checkVal({tag, ".frame"}, int'(frame_idx),    modelFrame());
        checkVal({tag, ".act"},   int'(punch_active), modelActive());
    endtask

    task automatic applyStimulus(input string tag, input bit kl, input bit kr, input bit kj,
                                 input bit kp, input bit tk, input bit frz, input bit rst);
        @(negedge Clk);
        key_left = kl; key_right = kr; key_jump = kj; key_punch = kp;
        opp_x = 10'(curOpp); frame_tick = tk; freeze = frz; Reset = rst;
        @(posedge Clk);
        #1;
        frame_tick = 1'b0;
        Reset = 1'b0;
        if (rst)
            modelReset();
        else if (tk && !frz)
            modelTick(kl, kr, kj, kp, curOpp);
        checkOutput(tag);
    endtask

    task automatic tickKeys(input string tag, input bit kl, input bit kr, input bit kj, input bit kp);
        applyStimulus(tag, kl, kr, kj, kp, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int x0;
        bit kl, kr, kj, kp, tk, frz, rst;

        modelReset();
        applyStimulus("reset", 0, 0, 0, 0, 0, 0, 1);
        checkVal("reset_x", int'(AkumaX), 100);
        checkVal("reset_y", int'(AkumaY), 240);
        checkVal("reset_state", int'(state), 0);
        checkVal("reset_frame", int'(frame_idx), 0);
        checkVal("reset_act", int'(punch_active), 0);

        // Hold right for ten frames
        for (int i = 1; i <= 10; i++) begin
            tickKeys("walk_r", 0, 1, 0, 0);
            if (i == 7) checkVal("walk_frame7", int'(frame_idx), 1);
        end
        checkVal("walk_x130", int'(AkumaX), 130);
        checkVal("walk_state", int'(state), 1);

        // Walk into the left wall
        for (int i = 1; i <= 44; i++) begin
            tickKeys("walk_l", 1, 0, 0, 0);
            if (i == 43) checkVal("left_x1", int'(AkumaX), 1);
        end
        checkVal("left_clamp0", int'(AkumaX), 0);

        // Walk into the right wall
        for (int i = 1; i <= 166; i++) tickKeys("walk_r2", 0, 1, 0, 0);
        checkVal("right_x498", int'(AkumaX), 498);
        tickKeys("walk_r3", 0, 1, 0, 0);
        checkVal("right_clamp499", int'(AkumaX), 499);
        tickKeys("walk_r4", 0, 1, 0, 0);
        checkVal("right_hold499", int'(AkumaX), 499);

        for (int i = 1; i <= 100; i++) tickKeys("walk_back", 1, 0, 0, 0);
        checkVal("back_x199", int'(AkumaX), 199);
        tickKeys("idle", 0, 0, 0, 0);
        checkVal("idle_state", int'(state), 0);

        // Jump to the right; keys ignored and opponent moves mid-air
        tickKeys("jump_entry", 0, 1, 1, 0);
        checkVal("jump_entry_y", int'(AkumaY), 240);
        checkVal("jump_entry_state", int'(state), 2);
        x0 = int'(AkumaX);
        for (int t = 1; t <= 25; t++) begin
            if (t == 6) curOpp = 50;
            tickKeys("jump_air", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checkVal("jump_x", int'(AkumaX), x0 + 3 * t);
            if (t == 1) checkVal("jump_y1", int'(AkumaY), 228);
            if (t == 5) checkVal("jump_frame_up", int'(frame_idx), 4);
            if (t == 12) checkVal("jump_peak", int'(AkumaY), 162);
            if (t == 14) checkVal("jump_frame_down", int'(frame_idx), 5);
            if (t == 24) checkVal("jump_air24", int'(state), 2);
        end
        checkVal("land_y", int'(AkumaY), 240);
        checkVal("land_state", int'(state), 0);
        checkVal("jump_face_frozen", int'(facing_left), 0);

        // Straight jump with a freeze window mid-air
        curOpp = 300;
        tickKeys("jump2_entry", 0, 0, 1, 0);
        for (int t = 1; t <= 3; t++) tickKeys("jump2_air", 0, 0, 0, 0);
        checkVal("jump2_y3", int'(AkumaY), 207);
        for (int t = 1; t <= 5; t++) begin
            applyStimulus("freeze", 1, 0, 0, 1, 1, 1, 0);
            checkVal("freeze_y", int'(AkumaY), 207);
        end
        for (int t = 4; t <= 25; t++) tickKeys("jump2_rest", 0, 0, 0, 0);
        checkVal("jump2_land_y", int'(AkumaY), 240);
        checkVal("jump2_land_state", int'(state), 0);

        // Punch, with jump held throughout
        tickKeys("punch_entry", 0, 0, 0, 1);
        checkVal("punch_state", int'(state), 3);
        checkVal("punch_frame", int'(frame_idx), 6);
        for (int k = 1; k <= 12; k++) begin
            tickKeys("punch", 0, 0, 1, 0);
            checkVal("punch_act", int'(punch_active), (k >= 3 && k <= 8) ? 1 : 0);
            checkVal("punch_st", int'(state), (k < 12) ? 3 : 0);
        end

        // Both directions held, opponent to the left
        x0 = int'(AkumaX);
        curOpp = 50;
        tickKeys("both", 1, 1, 0, 0);
        checkVal("both_state", int'(state), 0);
        checkVal("both_x", int'(AkumaX), x0);
        checkVal("face_left", int'(facing_left), 1);

        // Reset in the middle of a punch
        tickKeys("punch2", 0, 0, 0, 1);
        for (int k = 1; k <= 4; k++) tickKeys("punch2_run", 0, 0, 0, 0);
        applyStimulus("reset_mid", 0, 0, 0, 1, 1, 0, 1);
        checkVal("rst_x", int'(AkumaX), 100);
        checkVal("rst_y", int'(AkumaY), 240);
        checkVal("rst_state", int'(state), 0);
        checkVal("rst_face", int'(facing_left), 0);
        checkVal("rst_act", int'(punch_active), 0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            kl  = 1'($urandom_range(0, 1));
            kr  = 1'($urandom_range(0, 1));
            kj  = ($urandom_range(0, 5) == 0);
            kp  = ($urandom_range(0, 7) == 0);
            tk  = ($urandom_range(0, 5) != 0);
            frz = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 9) == 0) curOpp = int'($urandom_range(0, 639));
            applyStimulus("rand", kl, kr, kj, kp, tk, frz, rst);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
